// File: rtl/motion_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// motion_ramp_ctrl_if
// Link between the ramp controller and the step-pulse generator.
//   SpeedCmd     : speed word offered to the pulse generator
//   SpeedSet     : load request, held until SpeedSetDone is seen high
//   SpeedSetDone : load acknowledge from the pulse generator
//   PlsIn        : step pulse train from the pulse generator (asynchronous)
// Modports: master = controller side, slave = pulse generator side.
// -----------------------------------------------------------------------------
interface motion_ramp_ctrl_if;
   logic [7:0] SpeedCmd;
   logic       SpeedSet;
   logic       SpeedSetDone;
   logic       PlsIn;

   modport master (
      output SpeedCmd,
      output SpeedSet,
      input  SpeedSetDone,
      input  PlsIn
   );

   modport slave (
      input  SpeedCmd,
      input  SpeedSet,
      output SpeedSetDone,
      output PlsIn
   );
endinterface

// File: rtl/motion_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motion_ramp_ctrl
// Trapezoidal speed-ramp controller for a step-pulse generator. A move ramps
// the speed up in STEP increments every AccelDiv+1 clocks, cruises at the
// target, ramps down early enough to mirror the pulses spent accelerating,
// and finally commands speed 0 before reporting Done.
// Ports:
//   Clk          : clock, all state on rising edge
//   sCntClr      : asynchronous active-high reset
//   Start        : move request (IDLE only)
//   Abort        : terminate the active move
//   TargetSpeed  : cruise speed word
//   StepCount    : pulses to emit for the move
//   AccelDiv     : ramp tick period minus one
//   Busy         : high whenever not IDLE
//   Done         : one-cycle move-complete strobe
//   Aborted      : last move was ended by Abort
//   PlsCnt       : pulses counted in the current or last move
//   pg           : handshake / pulse link to the pulse generator (master)
// -----------------------------------------------------------------------------
module motion_ramp_ctrl #(
   parameter int unsigned STEP      = 1,
   parameter int unsigned MIN_SPEED = 1
) (
   input  logic               Clk,
   input  logic               sCntClr,
   input  logic               Start,
   input  logic               Abort,
   input  logic [7:0]         TargetSpeed,
   input  logic [15:0]        StepCount,
   input  logic [7:0]         AccelDiv,
   output logic               Busy,
   output logic               Done,
   output logic               Aborted,
   output logic [15:0]        PlsCnt,
   motion_ramp_ctrl_if.master pg
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCEL  = 3'd1;
   localparam logic [2:0] CRUISE = 3'd2;
   localparam logic [2:0] DECEL  = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam logic [8:0] STEP_W = 9'(STEP);
   localparam logic [8:0] MIN_W  = 9'(MIN_SPEED);

   logic [2:0]  state_q, state_d;
   logic [7:0]  target_q;
   logic [15:0] stepCnt_q;
   logic [7:0]  accelDiv_q;
   logic [7:0]  speed_q;
   logic [7:0]  tickCnt_q;
   logic [15:0] accCnt_q;
   logic [15:0] plsCnt_q;
   logic        aborted_q;
   logic [7:0]  speedCmd_q;
   logic        speedSet_q;
   logic        ackWait_q;
   logic        stopSent_q;
   logic        busy_q;
   logic        done_q;
   logic        plsSync1_q, plsSync2_q, plsPrev_q;

   logic        plsEdge_s;
   logic        hsBusy_s;
   logic        tick_s;
   logic [15:0] remain_s;
   logic        decelReq_s;
   logic [8:0]  sum_s;
   logic [7:0]  upSpeed_s;
   logic [7:0]  downSpeed_s;
   logic        issue_s;
   logic [7:0]  issueVal_s;
   logic        setAbort_s;

   // Datapath helpers: pulse edge, handshake activity, ramp tick, ramp targets
   always_comb begin
      plsEdge_s = plsSync2_q & ~plsPrev_q;
      // Handshake counts as pending until the ack has also returned low
      hsBusy_s  = speedSet_q | ackWait_q;
      tick_s    = (tickCnt_q == accelDiv_q);
      // Pulses still to go, clamped at zero once the count is met or exceeded
      if (plsCnt_q >= stepCnt_q) begin
         remain_s = 16'd0;
      end else begin
         remain_s = stepCnt_q - plsCnt_q;
      end
      decelReq_s = (remain_s <= accCnt_q);
      // 9-bit sum so speed+STEP cannot wrap past 255 before the clamp
      sum_s = {1'b0, speed_q} + STEP_W;
      if (sum_s >= {1'b0, target_q}) begin
         upSpeed_s = target_q;
      end else begin
         upSpeed_s = sum_s[7:0];
      end
      // Subtract only when the result stays at or above the floor
      if ({1'b0, speed_q} >= (MIN_W + STEP_W)) begin
         downSpeed_s = speed_q - STEP_W[7:0];
      end else begin
         downSpeed_s = MIN_W[7:0];
      end
   end

   // Next-state logic and speed-change issue decisions
   always_comb begin
      state_d    = state_q;
      issue_s    = 1'b0;
      issueVal_s = speed_q;
      setAbort_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if ((StepCount == 16'd0) || (TargetSpeed == 8'd0)) begin
                  state_d = STOP;
               end else begin
                  state_d = ACCEL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCEL: begin
            if (Abort) begin
               setAbort_s = 1'b1;
               state_d    = STOP;
            end else if (decelReq_s) begin
               state_d = DECEL;
            end else if ((speed_q == target_q) && !hsBusy_s) begin
               state_d = CRUISE;
            end else if (tick_s && !hsBusy_s && (upSpeed_s != speed_q)) begin
               // A tick landing on a pending handshake is simply dropped
               issue_s    = 1'b1;
               issueVal_s = upSpeed_s;
            end else begin
               state_d = ACCEL;
            end
         end
         CRUISE: begin
            if (Abort) begin
               setAbort_s = 1'b1;
               state_d    = STOP;
            end else if (decelReq_s) begin
               state_d = DECEL;
            end else begin
               state_d = CRUISE;
            end
         end
         DECEL: begin
            if (Abort) begin
               setAbort_s = 1'b1;
               state_d    = STOP;
            end else if (plsCnt_q >= stepCnt_q) begin
               state_d = STOP;
            end else if (tick_s && !hsBusy_s && (downSpeed_s != speed_q)) begin
               issue_s    = 1'b1;
               issueVal_s = downSpeed_s;
            end else begin
               state_d = DECEL;
            end
         end
         STOP: begin
            // Let any in-flight handshake finish, send zero, wait for it too
            if (hsBusy_s) begin
               state_d = STOP;
            end else if (stopSent_q) begin
               state_d = DONE;
            end else begin
               issue_s    = 1'b1;
               issueVal_s = 8'd0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters, handshake and registered outputs
   always_ff @(posedge Clk or posedge sCntClr) begin
      if (sCntClr) begin
         state_q    <= IDLE;
         target_q   <= 8'd0;
         stepCnt_q  <= 16'd0;
         accelDiv_q <= 8'd0;
         speed_q    <= 8'd0;
         tickCnt_q  <= 8'd0;
         accCnt_q   <= 16'd0;
         plsCnt_q   <= 16'd0;
         aborted_q  <= 1'b0;
         speedCmd_q <= 8'd0;
         speedSet_q <= 1'b0;
         ackWait_q  <= 1'b0;
         stopSent_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         plsSync1_q <= 1'b0;
         plsSync2_q <= 1'b0;
         plsPrev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
         plsSync1_q <= pg.PlsIn;
         plsSync2_q <= plsSync1_q;
         plsPrev_q  <= plsSync2_q;

         if ((state_q == IDLE) && Start) begin
            target_q   <= TargetSpeed;
            stepCnt_q  <= StepCount;
            accelDiv_q <= AccelDiv;
            plsCnt_q   <= 16'd0;
            accCnt_q   <= 16'd0;
            aborted_q  <= 1'b0;
         end else begin
            if ((state_q != IDLE) && plsEdge_s && (plsCnt_q != 16'hFFFF)) begin
               plsCnt_q <= plsCnt_q + 16'd1;
            end
            if ((state_q == ACCEL) && plsEdge_s && (accCnt_q != 16'hFFFF)) begin
               accCnt_q <= accCnt_q + 16'd1;
            end
            if (setAbort_s) begin
               aborted_q <= 1'b1;
            end
         end

         // Tick counter runs only while staying in a ramp state
         if (((state_q == ACCEL) || (state_q == DECEL)) && (state_d == state_q)) begin
            tickCnt_q <= tick_s ? 8'd0 : tickCnt_q + 8'd1;
         end else begin
            tickCnt_q <= 8'd0;
         end

         if (issue_s) begin
            speedCmd_q <= issueVal_s;
            speed_q    <= issueVal_s;
            speedSet_q <= 1'b1;
         end else if (speedSet_q && pg.SpeedSetDone) begin
            speedSet_q <= 1'b0;
            ackWait_q  <= 1'b1;
         end else if (ackWait_q && !pg.SpeedSetDone) begin
            ackWait_q <= 1'b0;
         end

         if (state_q != STOP) begin
            stopSent_q <= 1'b0;
         end else if (issue_s) begin
            stopSent_q <= 1'b1;
         end
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Aborted     = aborted_q;
   assign PlsCnt      = plsCnt_q;
   assign pg.SpeedCmd = speedCmd_q;
   assign pg.SpeedSet = speedSet_q;

endmodule

// File: tb/tb_motion_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motion_ramp_ctrl
// Bench for motion_ramp_ctrl with a behavioural pulse generator (acks each
// speed load after a programmable latency, emits a capped number of pulses
// at a speed-dependent rate) and a monitor collecting the commanded speeds.
// -----------------------------------------------------------------------------
module tb_motion_ramp_ctrl;
   localparam int STEP      = 1;
   localparam int MIN_SPEED = 1;

   logic        Clk = 1'b0;
   logic        sCntClr, Start, Abort;
   logic [7:0]  TargetSpeed, AccelDiv;
   logic [15:0] StepCount;
   logic        Busy, Done, Aborted;
   logic [15:0] PlsCnt;

   motion_ramp_ctrl_if pg_if ();

   motion_ramp_ctrl #(.STEP(STEP), .MIN_SPEED(MIN_SPEED)) dut (
      .Clk         (Clk),
      .sCntClr     (sCntClr),
      .Start       (Start),
      .Abort       (Abort),
      .TargetSpeed (TargetSpeed),
      .StepCount   (StepCount),
      .AccelDiv    (AccelDiv),
      .Busy        (Busy),
      .Done        (Done),
      .Aborted     (Aborted),
      .PlsCnt      (PlsCnt),
      .pg          (pg_if.master)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;
   int move_id = 0;
   int budget = 0;
   int ack_lat = 2;

   // pulse generator model state
   int pg_speed = 0;
   int emitted = 0;
   int ack_cnt = 0;
   int phase = 0;
   int pg_id = 0;

   // monitor state
   int cmd_q[$];
   int done_cnt = 0;
   int mon_id = 0;
   logic prev_set = 1'b0;

   // Pulse generator: ack after ack_lat cycles, pulses while speed nonzero
   always @(negedge Clk) begin
      if (sCntClr) begin
         pg_if.SpeedSetDone = 1'b0;
         pg_if.PlsIn        = 1'b0;
         pg_speed = 0; ack_cnt = 0; phase = 0;
      end else begin
         if (move_id != pg_id) begin
            pg_id = move_id; emitted = 0;
         end
         if (pg_if.SpeedSet && (pg_if.SpeedCmd == 8'd0)) pg_speed = 0;
         if (pg_if.SpeedSet && !pg_if.SpeedSetDone) begin
            if (ack_cnt + 1 >= ack_lat) begin
               pg_if.SpeedSetDone = 1'b1;
               pg_speed = int'(pg_if.SpeedCmd);
               ack_cnt = 0;
            end else begin
               ack_cnt++;
            end
         end else if (!pg_if.SpeedSet) begin
            pg_if.SpeedSetDone = 1'b0;
            ack_cnt = 0;
         end
         if (pg_if.PlsIn) begin
            pg_if.PlsIn = 1'b0;
         end else if (pg_speed != 0 && emitted < budget && phase == 0) begin
            pg_if.PlsIn = 1'b1;
            emitted++;
            phase = 12 - ((pg_speed > 8) ? 8 : pg_speed);
         end
         if (phase != 0) phase--;
      end
   end

   // Monitor: log speed words at each load request, count Done strobes
   always @(negedge Clk) begin
      if (move_id != mon_id) begin
         mon_id = move_id; cmd_q.delete(); done_cnt = 0;
      end
      if (pg_if.SpeedSet === 1'b1 && prev_set !== 1'b1) cmd_q.push_back(int'(pg_if.SpeedCmd));
      prev_set = pg_if.SpeedSet;
      if (Done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic start_move(input logic [7:0] ts, input logic [15:0] sc, input logic [7:0] ad);
      TargetSpeed = ts; StepCount = sc; AccelDiv = ad;
      budget = int'(sc);
      move_id++;
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string tag);
      int c = 0;
      while (!(done_cnt > 0 && Busy === 1'b0) && c < limit) begin
         @(negedge Clk); c++;
      end
      chk({tag, " timeout"}, 32'(c < limit), 32'd1);
   endtask

   // Ramp rules: rise by STEP capped at target, then fall by STEP floored
   // at MIN_SPEED, ending with a single zero command.
   function automatic bit ramp_ok(input int tgt);
      int prev, v, up, dn;
      bit falling;
      if (cmd_q.size() == 0) return 1'b0;
      if (cmd_q[cmd_q.size()-1] != 0) return 1'b0;
      prev = 0; falling = 1'b0;
      for (int i = 0; i < cmd_q.size() - 1; i++) begin
         v  = cmd_q[i];
         up = (prev + STEP > tgt) ? tgt : prev + STEP;
         dn = (prev - STEP < MIN_SPEED) ? MIN_SPEED : prev - STEP;
         if (!falling && v > prev && v == up) begin
            prev = v;
         end else if (prev > 0 && v < prev && v == dn) begin
            falling = 1'b1; prev = v;
         end else begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   function automatic int peak();
      int p = 0;
      foreach (cmd_q[i]) if (cmd_q[i] > p) p = cmd_q[i];
      return p;
   endfunction

   function automatic int falls();
      int f = 0;
      for (int i = 1; i < cmd_q.size() - 1; i++) if (cmd_q[i] < cmd_q[i-1]) f++;
      return f;
   endfunction

   initial begin
      int c, snap, p;
      logic [7:0] ts, ad;
      logic [15:0] sc;

      sCntClr = 1'b1; Start = 1'b0; Abort = 1'b0;
      TargetSpeed = 8'd0; StepCount = 16'd0; AccelDiv = 8'd0;
      tick(3);
      chk("rst SpeedCmd", 32'(pg_if.SpeedCmd), 32'd0);
      chk("rst SpeedSet", 32'(pg_if.SpeedSet), 32'd0);
      chk("rst Busy", 32'(Busy), 32'd0);
      chk("rst Done", 32'(Done), 32'd0);
      chk("rst Aborted", 32'(Aborted), 32'd0);
      chk("rst PlsCnt", 32'(PlsCnt), 32'd0);
      sCntClr = 1'b0;
      tick(2);

      // Full trapezoid: 1,2,3,4, cruise, ramp down, zero
      ack_lat = 2;
      start_move(8'd4, 16'd1000, 8'd0);
      chk("t1 Busy", 32'(Busy), 32'd1);
      wait_done(20000, "t1");
      chk("t1 first1", 32'(cmd_q.size() > 3 ? cmd_q[0] : -1), 32'd1);
      chk("t1 first2", 32'(cmd_q.size() > 3 ? cmd_q[1] : -1), 32'd2);
      chk("t1 first3", 32'(cmd_q.size() > 3 ? cmd_q[2] : -1), 32'd3);
      chk("t1 first4", 32'(cmd_q.size() > 3 ? cmd_q[3] : -1), 32'd4);
      chk("t1 ramp", 32'(ramp_ok(4)), 32'd1);
      chk("t1 peak", 32'(peak()), 32'd4);
      chk("t1 decel", 32'(falls() > 0), 32'd1);
      chk("t1 done", 32'(done_cnt), 32'd1);
      chk("t1 PlsCnt", 32'(PlsCnt), 32'd1000);
      chk("t1 Aborted", 32'(Aborted), 32'd0);

      // Short move: decel starts long before the target
      start_move(8'd200, 16'd6, 8'd0);
      wait_done(5000, "t2");
      chk("t2 ramp", 32'(ramp_ok(200)), 32'd1);
      chk("t2 peak<tgt", 32'(peak() < 200), 32'd1);
      chk("t2 decel", 32'(falls() > 0), 32'd1);
      chk("t2 PlsCnt", 32'(PlsCnt), 32'd6);
      chk("t2 done", 32'(done_cnt), 32'd1);

      // Zero-length move: only the zero command
      start_move(8'd50, 16'd0, 8'd3);
      wait_done(200, "t3");
      chk("t3 ncmd", 32'(cmd_q.size()), 32'd1);
      chk("t3 cmd0", 32'(cmd_q.size() > 0 ? cmd_q[0] : -1), 32'd0);
      chk("t3 PlsCnt", 32'(PlsCnt), 32'd0);
      chk("t3 done", 32'(done_cnt), 32'd1);

      // Abort during cruise, Start ignored while busy, Abort ignored in IDLE
      start_move(8'd4, 16'd1000, 8'd0);
      c = 0;
      while (!(pg_speed == 4 && !pg_if.SpeedSet && !pg_if.SpeedSetDone) && c < 500) begin
         tick(1); c++;
      end
      chk("t4 cruise timeout", 32'(c < 500), 32'd1);
      TargetSpeed = 8'd1; StepCount = 16'd5; Start = 1'b1;
      tick(1);
      Start = 1'b0;
      tick(3);
      chk("t4 busy start ignored", 32'(pg_if.SpeedCmd), 32'd4);
      chk("t4 Busy", 32'(Busy), 32'd1);
      Abort = 1'b1;
      tick(1);
      Abort = 1'b0;
      tick(1);
      chk("t4 Aborted", 32'(Aborted), 32'd1);
      wait_done(200, "t4");
      chk("t4 last0", 32'(cmd_q[cmd_q.size()-1]), 32'd0);
      chk("t4 done", 32'(done_cnt), 32'd1);
      chk("t4 PlsCnt", 32'(PlsCnt), 32'(emitted));
      snap = int'(PlsCnt);
      Abort = 1'b1;
      tick(3);
      Abort = 1'b0;
      tick(2);
      chk("t4 idle Busy", 32'(Busy), 32'd0);
      chk("t4 idle Aborted hold", 32'(Aborted), 32'd1);
      chk("t4 idle PlsCnt hold", 32'(PlsCnt), 32'(snap));

      // Slow acknowledge: request held, no skipped increments afterwards
      ack_lat = 50;
      start_move(8'd10, 16'd1000, 8'd0);
      c = 0;
      while (pg_if.SpeedSet !== 1'b1 && c < 20) begin tick(1); c++; end
      chk("t5 set timeout", 32'(c < 20), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick(10);
         chk("t5 SpeedSet held", 32'(pg_if.SpeedSet), 32'd1);
         chk("t5 SpeedCmd held", 32'(pg_if.SpeedCmd), 32'd1);
      end
      c = 0;
      while (pg_if.SpeedSetDone !== 1'b1 && c < 30) begin tick(1); c++; end
      ack_lat = 2;
      wait_done(20000, "t5");
      chk("t5 second", 32'(cmd_q.size() > 2 ? cmd_q[1] : -1), 32'd2);
      chk("t5 ramp", 32'(ramp_ok(10)), 32'd1);
      chk("t5 peak", 32'(peak()), 32'd10);
      chk("t5 PlsCnt", 32'(PlsCnt), 32'd1000);

      // Reset during ACCEL: immediate clear, no Done, restart works
      start_move(8'd8, 16'd1000, 8'd2);
      tick(8);
      sCntClr = 1'b1;
      #1;
      chk("t6 SpeedCmd", 32'(pg_if.SpeedCmd), 32'd0);
      chk("t6 SpeedSet", 32'(pg_if.SpeedSet), 32'd0);
      chk("t6 Busy", 32'(Busy), 32'd0);
      chk("t6 Done", 32'(Done), 32'd0);
      chk("t6 PlsCnt", 32'(PlsCnt), 32'd0);
      tick(3);
      sCntClr = 1'b0;
      tick(2);
      chk("t6 no done", 32'(done_cnt), 32'd0);
      start_move(8'd3, 16'd20, 8'd0);
      wait_done(2000, "t6b");
      chk("t6b ramp", 32'(ramp_ok(3)), 32'd1);
      chk("t6b PlsCnt", 32'(PlsCnt), 32'd20);
      chk("t6b done", 32'(done_cnt), 32'd1);

      // Randomised moves
      for (int k = 0; k < 4; k++) begin
         ts = 8'($urandom_range(12, 1));
         sc = 16'($urandom_range(300, 20));
         ad = 8'($urandom_range(3, 0));
         ack_lat = $urandom_range(4, 1);
         start_move(ts, sc, ad);
         wait_done(30000, "rnd");
         p = peak();
         chk("rnd ramp", 32'(ramp_ok(int'(ts))), 32'd1);
         chk("rnd peak", 32'(p <= int'(ts)), 32'd1);
         chk("rnd PlsCnt", 32'(PlsCnt), 32'(sc));
         chk("rnd done", 32'(done_cnt), 32'd1);
         chk("rnd Aborted", 32'(Aborted), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
